// File: rtl/axi_lite_regtest_master.sv
// axi_lite_regtest_master
// AXI4-Lite register self-test master. On a start pulse it writes NUM_REGS generated
// words to a register window, reads each one back right after its write, compares,
// and reports pass/fail with a saturating error count and the first failing index.
// Optional build macro: REGTEST_TIMEOUT_EN enables a per-state watchdog that aborts a
// stalled handshake after TIMEOUT_CYCLES cycles.

module axi_lite_regtest_master #(
    parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                    NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  BASE_ADDR          = '0,
    parameter int unsigned                    ADDR_STRIDE        = 4,
    parameter logic [31:0]                    PATTERN_BASE       = 32'h0101FFFF,
    parameter logic [31:0]                    PATTERN_STEP       = 32'h11111111,
    parameter int unsigned                    TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [7:0]                        err_count,
    output logic [7:0]                        first_err_idx,
    output logic                              timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    localparam logic [AW-1:0] L_STRIDE = AW'(ADDR_STRIDE);
    localparam logic [DW-1:0] L_PBASE  = DW'(PATTERN_BASE);
    localparam logic [DW-1:0] L_PSTEP  = DW'(PATTERN_STEP);
    localparam logic [7:0]    L_LAST   = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle, StWr, StWb, StRa, StRd, StCmp, StNext, StDone
    } state_e;

    state_e          r_state, w_state_next;
    logic [7:0]      r_idx, w_idx_next;
    logic [AW-1:0]   r_addr, w_addr_next;
    logic [DW-1:0]   r_data, w_data_next;
    logic [DW-1:0]   r_rdata, w_rdata_next;
    logic [1:0]      r_rresp, w_rresp_next;
    logic            r_awvalid, w_awvalid_next;
    logic            r_wvalid, w_wvalid_next;
    logic [7:0]      r_err_count, w_err_count_next;
    logic [7:0]      r_first_err, w_first_err_next;
    logic            r_done, w_done_next;
    logic            r_pass, w_pass_next;
    logic            r_timeout, w_timeout_next;
    logic            w_err_event;

`ifdef REGTEST_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0]   r_tcnt;
    logic            w_wait_state;

    assign w_wait_state = (r_state == StWr) || (r_state == StWb) ||
                          (r_state == StRa) || (r_state == StRd);

    // Watchdog: restarts on every state change, counts only while waiting on the slave
    always_ff @(posedge ACLK) begin
        if (ARESET || (w_state_next != r_state)) begin
            r_tcnt <= '0;
        end else if (w_wait_state) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // State and datapath registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_rresp     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_err_count <= '0;
            r_first_err <= 8'hFF;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_addr      <= w_addr_next;
            r_data      <= w_data_next;
            r_rdata     <= w_rdata_next;
            r_rresp     <= w_rresp_next;
            r_awvalid   <= w_awvalid_next;
            r_wvalid    <= w_wvalid_next;
            r_err_count <= w_err_count_next;
            r_first_err <= w_first_err_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
            r_timeout   <= w_timeout_next;
        end
    end

    // Next-state, channel sequencing and error accounting
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_addr_next      = r_addr;
        w_data_next      = r_data;
        w_rdata_next     = r_rdata;
        w_rresp_next     = r_rresp;
        w_awvalid_next   = r_awvalid;
        w_wvalid_next    = r_wvalid;
        w_err_count_next = r_err_count;
        w_first_err_next = r_first_err;
        w_done_next      = r_done;
        w_pass_next      = r_pass;
        w_timeout_next   = r_timeout;
        w_err_event      = 1'b0;

        case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_next     = StWr;
                    w_idx_next       = '0;
                    w_addr_next      = BASE_ADDR;
                    w_data_next      = L_PBASE;
                    w_awvalid_next   = 1'b1;
                    w_wvalid_next    = 1'b1;
                    w_err_count_next = '0;
                    w_first_err_next = 8'hFF;
                    w_done_next      = 1'b0;
                    w_pass_next      = 1'b0;
                    w_timeout_next   = 1'b0;
                end
            end
            StWr: begin
                // A valid already low means its handshake completed in an earlier cycle
                if (r_awvalid && m_axi_awready) w_awvalid_next = 1'b0;
                if (r_wvalid && m_axi_wready)   w_wvalid_next  = 1'b0;
                if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready)) begin
                    w_state_next = StWb;
                end
            end
            StWb: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) w_err_event = 1'b1;
                    w_state_next = StRa;
                end
            end
            StRa: begin
                if (m_axi_arready) w_state_next = StRd;
            end
            StRd: begin
                if (m_axi_rvalid) begin
                    w_rdata_next = m_axi_rdata;
                    w_rresp_next = m_axi_rresp;
                    w_state_next = StCmp;
                end
            end
            StCmp: begin
                if ((r_rresp != 2'b00) || (r_rdata != r_data)) w_err_event = 1'b1;
                w_state_next = StNext;
            end
            StNext: begin
                if (r_idx == L_LAST) begin
                    w_state_next = StDone;
                    w_done_next  = 1'b1;
                    w_pass_next  = (r_err_count == 8'd0) && !r_timeout;
                end else begin
                    w_state_next   = StWr;
                    w_idx_next     = r_idx + 8'd1;
                    w_addr_next    = r_addr + L_STRIDE;
                    w_data_next    = r_data + L_PSTEP;
                    w_awvalid_next = 1'b1;
                    w_wvalid_next  = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase

`ifdef REGTEST_TIMEOUT_EN
        // A handshake completing in the expiry cycle still wins over the abort
        if (w_wait_state && (w_state_next == r_state) &&
            (r_tcnt == TW'(TIMEOUT_CYCLES - 1))) begin
            w_state_next   = StDone;
            w_awvalid_next = 1'b0;
            w_wvalid_next  = 1'b0;
            w_timeout_next = 1'b1;
            w_done_next    = 1'b1;
            w_pass_next    = 1'b0;
            w_err_event    = 1'b1;
        end
`endif

        if (w_err_event) begin
            if (r_err_count != 8'hFF) w_err_count_next = r_err_count + 8'd1;
            if (r_first_err == 8'hFF) w_first_err_next = r_idx;
        end
    end

    assign busy          = (r_state != StIdle) && (r_state != StDone);
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err;
    assign timeout       = r_timeout;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_data;
    assign m_axi_wstrb   = {(DW/8){1'b1}};
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == StWb);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (r_state == StRa);
    assign m_axi_rready  = (r_state == StRd);

endmodule

// File: tb/tb_axi_lite_regtest_master.sv
// Self-checking bench for axi_lite_regtest_master: a behavioural AXI4-Lite RAM slave
// with configurable stalls and error injection, and a reference model that derives the
// expected write stream and error accounting directly from the test-word rules.

module tb_axi_lite_regtest_master;

    localparam int          NREG = 4;
    localparam int          TMO  = 16;
    localparam logic [31:0] PB   = 32'h0101FFFF;
    localparam logic [31:0] PS   = 32'h11111111;

    logic        ACLK = 1'b0;
    logic        ARESET, start;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_count, first_err_idx;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 ACLK = ~ACLK;

    axi_lite_regtest_master #(
        .NUM_REGS       (NREG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .timeout       (timeout),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration; index -1 disables an injection
    int  cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_max = 0, cfg_r_max = 0;
    int  cfg_stuck = -1, cfg_bresp_idx = -1, cfg_rresp_idx = -1;
    bit  cfg_ar_never = 1'b0;

    logic [31:0] mem [0:255];
    int          aw_cnt, w_cnt;
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          ar_hs;

    assign awready = (aw_cnt >= cfg_aw_dly);
    assign wready  = (w_cnt >= cfg_w_dly);
    assign arready = !cfg_ar_never;

    // Behavioural RAM slave: accepts AW/W in any order, responds after a random delay
    always @(posedge ACLK) begin : slave
        bit          aw_now, w_now, aw_all, w_all;
        bit          aw_have, w_have, b_pend, r_pend;
        int          ix, dly, b_cnt, r_cnt;
        logic [31:0] lat_addr, lat_data, r_dat_p;
        logic [1:0]  b_resp_p, r_resp_p;
        if (ARESET) begin
            aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
            aw_cnt <= 0; w_cnt <= 0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
        end else begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            if (aw_now) begin lat_addr = awaddr; aw_cnt <= 0; end
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (w_now) begin lat_data = wdata; w_cnt <= 0; end
            else if (wvalid) w_cnt <= w_cnt + 1;

            if (bvalid && bready) bvalid <= 1'b0;
            if (b_pend) begin
                b_cnt--;
                if (b_cnt == 0) begin bvalid <= 1'b1; bresp <= b_resp_p; b_pend = 0; end
            end
            aw_all = aw_have || aw_now;
            w_all  = w_have || w_now;
            if (aw_all && w_all) begin
                ix = int'(lat_addr[9:2]);
                mem[ix] = lat_data;
                wr_addr_log.push_back(lat_addr);
                wr_data_log.push_back(lat_data);
                b_resp_p = (ix == cfg_bresp_idx) ? 2'b10 : 2'b00;
                dly = $urandom_range(cfg_b_max, 0);
                if (dly == 0) begin bvalid <= 1'b1; bresp <= b_resp_p; end
                else begin b_pend = 1; b_cnt = dly; end
                aw_have = 0; w_have = 0;
            end else begin
                aw_have = aw_all; w_have = w_all;
            end

            if (rvalid && rready) rvalid <= 1'b0;
            if (r_pend) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    rvalid <= 1'b1; rdata <= r_dat_p; rresp <= r_resp_p; r_pend = 0;
                end
            end
            if (arvalid && arready) begin
                ar_hs++;
                ix = int'(araddr[9:2]);
                r_dat_p  = (ix == cfg_stuck) ? 32'h0 : mem[ix];
                r_resp_p = (ix == cfg_rresp_idx) ? 2'b10 : 2'b00;
                dly = $urandom_range(cfg_r_max, 0);
                if (dly == 0) begin rvalid <= 1'b1; rdata <= r_dat_p; rresp <= r_resp_p; end
                else begin r_pend = 1; r_cnt = dly; end
            end
        end
    end

    // Protocol monitor: payload stability under stall, valid drop after handshake
    int viol, aw_hi, w_hi;
    always @(posedge ACLK) begin : monitor
        bit          p_aw_st, p_w_st, p_ar_st, p_aw_f, p_w_f;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        if (ARESET) begin
            p_aw_st = 0; p_w_st = 0; p_ar_st = 0; p_aw_f = 0; p_w_f = 0;
        end else begin
            if (p_aw_st && (!awvalid || awaddr !== p_awaddr)) viol++;
            if (p_w_st && (!wvalid || wdata !== p_wdata)) viol++;
            if (p_ar_st && (!arvalid || araddr !== p_araddr)) viol++;
            if (p_aw_f && awvalid) viol++;
            if (p_w_f && wvalid) viol++;
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            p_aw_st = awvalid && !awready; p_awaddr = awaddr;
            p_w_st  = wvalid && !wready;   p_wdata  = wdata;
            p_ar_st = arvalid && !arready; p_araddr = araddr;
            p_aw_f  = awvalid && awready;
            p_w_f   = wvalid && wready;
        end
    end

    // Reference: per register one write error (bad bresp) and at most one read error
    function automatic void model(input int stuck, input int be, input int re,
                                  output int errs, output int first);
        logic [31:0] d, got;
        errs = 0;
        first = 255;
        for (int i = 0; i < NREG; i++) begin
            d   = PB + PS * 32'(i);
            got = (i == stuck) ? 32'h0 : d;
            if (i == be) begin
                if (errs < 255) errs++;
                if (first == 255) first = i;
            end
            if ((i == re) || (got != d)) begin
                if (errs < 255) errs++;
                if (first == 255) first = i;
            end
        end
    endfunction

    task automatic pulse_start();
        @(posedge ACLK); #1 start = 1'b1;
        @(posedge ACLK); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "/busy"}, busy, 0);
        check_eq({tag, "/done"}, done, 0);
        check_eq({tag, "/pass"}, pass, 0);
        check_eq({tag, "/err"}, err_count, 0);
        check_eq({tag, "/first"}, first_err_idx, 8'hFF);
        check_eq({tag, "/timeout"}, timeout, 0);
        check_eq({tag, "/valids"}, {awvalid, wvalid, arvalid, bready, rready}, 0);
        check_eq({tag, "/addr_data"}, {awaddr, wdata}, 0);
    endtask

    task automatic run_case(input string name, input int aw_d, input int w_d, input int b_m,
                            input int r_m, input int stuck, input int be, input int re,
                            input bit chk_lat, input int exp_aw_hi, input int exp_w_hi);
        int cyc, e_err, e_first;
        cfg_aw_dly = aw_d; cfg_w_dly = w_d; cfg_b_max = b_m; cfg_r_max = r_m;
        cfg_stuck = stuck; cfg_bresp_idx = be; cfg_rresp_idx = re; cfg_ar_never = 0;
        wr_addr_log.delete(); wr_data_log.delete();
        viol = 0; aw_hi = 0; w_hi = 0;
        model(stuck, be, re, e_err, e_first);
        pulse_start();
        check_eq({name, "/start_busy"}, {busy, awvalid, wvalid, done}, 4'b1110);
        check_eq({name, "/prot_strb"}, {awprot, arprot, wstrb}, {6'b0, 4'hF});
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        check_eq({name, "/done"}, done, 1);
        if (chk_lat) check_eq({name, "/latency"}, cyc, 6 * NREG);
        check_eq({name, "/busy_end"}, busy, 0);
        check_eq({name, "/err_count"}, err_count, e_err);
        check_eq({name, "/first_err"}, first_err_idx, e_first);
        check_eq({name, "/pass"}, pass, (e_err == 0));
        check_eq({name, "/timeout"}, timeout, 0);
        check_eq({name, "/n_writes"}, wr_addr_log.size(), NREG);
        for (int i = 0; i < NREG && i < wr_addr_log.size(); i++) begin
            check_eq($sformatf("%s/waddr%0d", name, i), wr_addr_log[i], 32'(4 * i));
            check_eq($sformatf("%s/wdata%0d", name, i), wr_data_log[i], PB + PS * 32'(i));
        end
        check_eq({name, "/protocol"}, viol, 0);
        if (exp_aw_hi >= 0) check_eq({name, "/aw_cycles"}, aw_hi, exp_aw_hi);
        if (exp_w_hi >= 0) check_eq({name, "/w_cycles"}, w_hi, exp_w_hi);
    endtask

    initial begin
        int n, v1, v2, v3;
        ARESET = 1'b1;
        start  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        check_reset_state("reset");

        run_case("zero_wait", 0, 0, 0, 0, -1, -1, -1, 1, NREG, NREG);
        run_case("stuck2", 0, 0, 0, 0, 2, -1, -1, 1, -1, -1);
        run_case("slverr", 0, 0, 0, 0, -1, 1, 3, 1, -1, -1);
        run_case("aw_delay", 3, 0, 0, 4, -1, -1, -1, 0, 4 * NREG, NREG);

        for (int k = 0; k < 6; k++) begin
            v1 = $urandom_range(NREG, 0);
            v2 = $urandom_range(NREG, 0);
            v3 = $urandom_range(NREG, 0);
            run_case($sformatf("rand%0d", k), $urandom_range(3, 0), $urandom_range(3, 0),
                     $urandom_range(3, 0), $urandom_range(3, 0),
                     (v1 == NREG) ? -1 : v1, (v2 == NREG) ? -1 : v2,
                     (v3 == NREG) ? -1 : v3, 0, -1, -1);
        end

        // Read address channel that never accepts
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_max = 0; cfg_r_max = 0;
        cfg_stuck = -1; cfg_bresp_idx = -1; cfg_rresp_idx = -1; cfg_ar_never = 1;
        pulse_start();
        n = 0;
        while (!arvalid && n < 100) begin @(posedge ACLK); #1; n++; end
        check_eq("stall/arvalid_seen", arvalid, 1);
`ifdef REGTEST_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 200) begin @(posedge ACLK); #1; n++; end
        check_eq("tmo/latency", n, TMO);
        check_eq("tmo/flag", timeout, 1);
        check_eq("tmo/done", done, 1);
        check_eq("tmo/pass", pass, 0);
        check_eq("tmo/arvalid", arvalid, 0);
        check_eq("tmo/busy", busy, 0);
        check_eq("tmo/err_count", err_count, 1);
        check_eq("tmo/first_err", first_err_idx, 0);
`else
        repeat (200) @(posedge ACLK);
        #1;
        check_eq("hang/busy", busy, 1);
        check_eq("hang/arvalid", arvalid, 1);
        check_eq("hang/done", done, 0);
        check_eq("hang/timeout", timeout, 0);
`endif
        cfg_ar_never = 0;
        do_reset();
        check_reset_state("stall_reset");

        // Reset while reading register 2 back, then a clean rerun
        cfg_r_max = 5;
        ar_hs = 0;
        pulse_start();
        n = 0;
        while (!(ar_hs == 3 && rready) && n < 500) begin @(posedge ACLK); #1; n++; end
        check_eq("midrd/in_rd", {rready, 8'(ar_hs)}, {1'b1, 8'd3});
        do_reset();
        check_reset_state("midrd_reset");
        run_case("rerun", 0, 0, 0, 0, -1, -1, -1, 1, NREG, NREG);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_regtest_master.md
# axi_lite_regtest_master

Synthesizable AXI4-Lite register self-test master: on a start pulse it writes NUM_REGS generated test words to a register window of an AXI4-Lite slave, reads each back immediately, compares, and reports pass/fail with an error count. It sits beside a peripheral's S00_AXI port in a block design and replaces the simulation-only BFM write/read/compare sequence. The register count, address stride, data width and data pattern are parameters; error accounting and early abort are additions.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (32 or 64).
- NUM_REGS, 4, registers tested (1..256).
- BASE_ADDR, 0, first register address.
- ADDR_STRIDE, 4, address increment per register.
- PATTERN_BASE, 32'h0101FFFF, test word for register 0 (zero-extended to data width).
- PATTERN_STEP, 32'h11111111, added per register index, modulo 2^C_M_AXI_DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with REGTEST_TIMEOUT_EN.
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start request.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid when done: err_count==0 and timeout==0.
- err_count  out  8  saturating error count.
- first_err_idx  out  8  index of first failing register; 0xFF if none.
- timeout  out  1  watchdog abort flag.
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels; awprot=arprot=3'b000, wstrb all ones.

## Operation
- States: IDLE, WR, WB, RA, RD, CMP, NEXT, DONE.
- IDLE: start=1 clears err_count, timeout, done; sets first_err_idx=0xFF, idx=0, addr=BASE_ADDR, data=PATTERN_BASE; enters WR. start outside IDLE/DONE ignored. DONE accepts start like IDLE.
- WR: awvalid and wvalid assert together; each deasserts independently on its own handshake; both complete -> WB.
- WB: bready=1; on bvalid: bresp!=2'b00 counts one write error; -> RA.
- RA: arvalid=1 on same addr until arready -> RD.
- RD: rready=1; on rvalid capture rdata, rresp -> CMP.
- CMP: rresp!=OKAY or rdata!=data counts one read error (at most one per register per phase) -> NEXT.
- NEXT: idx==NUM_REGS-1 -> DONE; else idx+1, addr+=ADDR_STRIDE (wraps at 2^ADDR_WIDTH), data+=PATTERN_STEP (wraps) -> WR.
- Error count: increments saturate at 255; first error records idx into first_err_idx only if it is still 0xFF.
- DONE: busy=0, done=1, all valids/readies 0.
- Addresses and data are held stable while valid is high.

## Timing
- Reset values: all valid/ready outputs 0, addr/data outputs 0, busy 0, done 0, pass 0, err_count 0, first_err_idx 0xFF, timeout 0; state IDLE.
- ARESET mid-transaction: everything returns to reset values on the next edge; an outstanding slave handshake is abandoned.
- start sampled at edge T -> busy=1 and awvalid=wvalid=1 from T+1.
- Zero-wait slave (ready high, response the cycle after): WR 1, WB 1, RA 1, RD 1, CMP 1, NEXT 1 = 6 cycles per register; done rises 6*NUM_REGS cycles after start+1.
- AW and W handshakes in different cycles are legal; a valid drops in the cycle after its own handshake.
- pass is registered, updates with done.

## Configuration
- REGTEST_TIMEOUT_EN defined: a counter resets on every state change and increments in WR/WB/RA/RD; reaching TIMEOUT_CYCLES sets timeout=1, counts one error, drops all valid/ready outputs and jumps to DONE (pass=0).
- Undefined: no counter; the master waits indefinitely; timeout tied 0; TIMEOUT_CYCLES ignored.

## Test plan
- Zero-wait RAM slave, NUM_REGS=4 defaults -> writes 0x0101FFFF, 0x12131110, 0x23242221, 0x34353332 to 0x0,0x4,0x8,0xC; done after 24 cycles; pass=1, err_count=0, first_err_idx=0xFF.
- Slave with register 2 stuck at 0 -> err_count=1, first_err_idx=2, pass=0.
- Slave returns bresp=SLVERR on register 1 and rresp=SLVERR on register 3 -> err_count=2, first_err_idx=1.
- awready delayed 3 cycles, wready immediate, random rvalid delays -> wvalid drops after 1 cycle, awvalid holds stable until handshake; pass=1.
- With REGTEST_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never asserted -> timeout=1 16 cycles into RA, done=1, pass=0, arvalid=0; without the macro, busy stays 1.
- ARESET asserted in RD of register 2, then start -> outputs at reset values, rerun completes from register 0 with pass=1.
